// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Hazard/forwarding controller beside ID: operand forwarding,
//             load-use stall, bus-wait freeze, deferred redirect, perf counters.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
   parameter int XLEN         = 32,
   parameter int RA_W         = 5,
   parameter int NSTG         = 3,
   parameter int LOAD_RDY_STG = 1,
   parameter int CNT_W        = 32
) (
   input  logic                 cpu_clk,
   input  logic                 cpu_rst,
   input  logic                 id_valid,
   input  logic [RA_W-1:0]      id_rs1,
   input  logic [RA_W-1:0]      id_rs2,
   input  logic                 id_rs1_en,
   input  logic                 id_rs2_en,
   input  logic [XLEN-1:0]      id_rf_rdata1,
   input  logic [XLEN-1:0]      id_rf_rdata2,
   input  logic [NSTG-1:0]      stg_valid,
   input  logic [NSTG-1:0]      stg_wen,
   input  logic [NSTG-1:0]      stg_is_load,
   input  logic [NSTG*RA_W-1:0] stg_rd,
   input  logic [NSTG*XLEN-1:0] stg_data,
   input  logic                 ex_redirect,
   input  logic                 mem_ready,
   output logic [XLEN-1:0]      fwd_data1,
   output logic [XLEN-1:0]      fwd_data2,
   output logic                 stall_pc,
   output logic                 stall_ifid,
   output logic                 bubble_idex,
   output logic                 flush_ifid,
   output logic                 freeze,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt,
   output logic [CNT_W-1:0]     wait_cnt
);

   localparam int NCNT = 3;

   logic [RA_W-1:0] src_rs   [2];
   logic [XLEN-1:0] src_rf   [2];
   logic            src_en   [2];
   logic [XLEN-1:0] src_fwd  [2];
   logic            src_lu   [2];

   logic            load_use;
   logic            redir_now;
   logic            pend_redir_q;
   logic            pend_redir_d;

   logic [CNT_W-1:0] cnt_q   [NCNT];
   logic [CNT_W-1:0] cnt_d   [NCNT];
   logic             cnt_inc [NCNT];

   assign src_rs[0] = id_rs1;
   assign src_rs[1] = id_rs2;
   assign src_rf[0] = id_rf_rdata1;
   assign src_rf[1] = id_rf_rdata2;
   assign src_en[0] = id_rs1_en;
   assign src_en[1] = id_rs2_en;

   // Scan oldest to youngest so the youngest matching stage is written last and wins.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         src_fwd[s] = src_rf[s];
         src_lu[s]  = 1'b0;
         for (int k = NSTG - 1; k >= 0; k--) begin
            if (stg_valid[k] && stg_wen[k] && (src_rs[s] != '0) &&
                (stg_rd[k*RA_W +: RA_W] == src_rs[s])) begin
               src_fwd[s] = stg_data[k*XLEN +: XLEN];
               src_lu[s]  = stg_is_load[k] && (k < LOAD_RDY_STG);
            end
         end
         if (src_rs[s] == '0) begin
            src_fwd[s] = '0;
         end
         if (!cpu_rst) begin
            src_fwd[s] = src_rf[s];
            src_lu[s]  = 1'b0;
         end
      end
   end

   assign fwd_data1 = src_fwd[0];
   assign fwd_data2 = src_fwd[1];

   assign load_use  = id_valid && ((src_lu[0] && src_en[0]) || (src_lu[1] && src_en[1]));
   assign redir_now = mem_ready && (ex_redirect || pend_redir_q);

   always_comb begin
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      bubble_idex = 1'b0;
      flush_ifid  = 1'b0;
      freeze      = 1'b0;
      if (!cpu_rst) begin
         freeze = 1'b0;
      end else if (!mem_ready) begin
         freeze     = 1'b1;
         stall_pc   = 1'b1;
         stall_ifid = 1'b1;
      end else if (redir_now) begin
         flush_ifid  = 1'b1;
         bubble_idex = 1'b1;
      end else if (load_use) begin
         stall_pc    = 1'b1;
         stall_ifid  = 1'b1;
         bubble_idex = 1'b1;
      end
   end

   // A redirect seen during a bus wait is held until the first ready cycle applies it.
   always_comb begin
      pend_redir_d = pend_redir_q;
      if (mem_ready) begin
         pend_redir_d = 1'b0;
      end else if (ex_redirect) begin
         pend_redir_d = 1'b1;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         pend_redir_q <= 1'b0;
      end else begin
         pend_redir_q <= pend_redir_d;
      end
   end

   assign cnt_inc[0] = stall_pc && bubble_idex && !flush_ifid;
   assign cnt_inc[1] = flush_ifid;
   assign cnt_inc[2] = cpu_rst && !mem_ready;

   for (genvar i = 0; i < NCNT; i++) begin : g_cnt
      always_comb begin
         cnt_d[i] = cnt_q[i];
         if (cnt_inc[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end

      always_ff @(posedge cpu_clk or negedge cpu_rst) begin
         if (!cpu_rst) begin
            cnt_q[i] <= '0;
         end else begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign stall_cnt = cnt_q[0];
   assign flush_cnt = cnt_q[1];
   assign wait_cnt  = cnt_q[2];

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Scoreboard bench for pipe_hazard_ctrl (CNT_W=4 instance).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

   localparam int XLEN  = 32;
   localparam int RA_W  = 5;
   localparam int NSTG  = 3;
   localparam int CNT_W = 4;

   logic              cpu_clk;
   logic              cpu_rst;
   logic              id_valid;
   logic [RA_W-1:0]   id_rs1, id_rs2;
   logic              id_rs1_en, id_rs2_en;
   logic [XLEN-1:0]   id_rf_rdata1, id_rf_rdata2;
   logic [NSTG-1:0]   stg_valid, stg_wen, stg_is_load;
   logic [NSTG*RA_W-1:0] stg_rd;
   logic [NSTG*XLEN-1:0] stg_data;
   logic              ex_redirect, mem_ready;
   logic [XLEN-1:0]   fwd_data1, fwd_data2;
   logic              stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt, wait_cnt;

   wire [4:0] ctl = {stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze};

   localparam logic [4:0] C_NONE   = 5'b00000;
   localparam logic [4:0] C_STALL  = 5'b11100;
   localparam logic [4:0] C_FLUSH  = 5'b00110;
   localparam logic [4:0] C_FREEZE = 5'b11001;

   typedef struct packed {
      logic [4:0]      ctl;
      logic            chk1;
      logic [XLEN-1:0] d1;
      logic            chk2;
      logic [XLEN-1:0] d2;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;
   int   m_stall = 0, m_flush = 0, m_wait = 0;

   pipe_hazard_ctrl #(
      .XLEN(XLEN), .RA_W(RA_W), .NSTG(NSTG), .LOAD_RDY_STG(1), .CNT_W(CNT_W)
   ) dut (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
      .id_rf_rdata1(id_rf_rdata1), .id_rf_rdata2(id_rf_rdata2),
      .stg_valid(stg_valid), .stg_wen(stg_wen), .stg_is_load(stg_is_load),
      .stg_rd(stg_rd), .stg_data(stg_data), .ex_redirect(ex_redirect),
      .mem_ready(mem_ready), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
      .flush_ifid(flush_ifid), .freeze(freeze),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   function automatic int sat(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic set_idle();
      id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_en = 1'b0; id_rs2_en = 1'b0;
      id_rf_rdata1 = 32'hA1A1_0001; id_rf_rdata2 = 32'hB2B2_0002;
      stg_valid = '0; stg_wen = '0; stg_is_load = '0; stg_rd = '0; stg_data = '0;
      ex_redirect = 1'b0; mem_ready = 1'b1;
   endtask

   task automatic set_stg(input logic [2:0] v, input logic [2:0] w, input logic [2:0] ld,
                          input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
      stg_valid = v; stg_wen = w; stg_is_load = ld; stg_rd = {r2, r1, r0};
      stg_data = {32'h0000_0022, 32'h0000_0033, 32'h0000_0011};
   endtask

   task automatic next_cycle();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic push(input logic [4:0] c, input logic k1, input logic [31:0] a,
                       input logic k2, input logic [31:0] b);
      sb.push_back('{ctl: c, chk1: k1, d1: a, chk2: k2, d2: b});
   endtask

   task automatic test_reset();
      set_idle();
      cpu_rst = 1'b0;
      mem_ready = 1'b0;
      ex_redirect = 1'b1;
      id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_en = 1'b1;
      set_stg(3'b001, 3'b001, 3'b000, 5'd5, 5'd0, 5'd0);
      #12;
      n_vec++;
      if (ctl !== C_NONE) begin
         n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE);
      end
      n_vec++;
      if (fwd_data1 !== id_rf_rdata1) begin
         n_err++; $display("FAIL reset_fwd1: got %h want %h", fwd_data1, 32'hA1A1_0001);
      end
      n_vec++;
      if ({stall_cnt, flush_cnt, wait_cnt} !== 12'h000) begin
         n_err++; $display("FAIL reset_cnt: got %h want 000", {stall_cnt, flush_cnt, wait_cnt});
      end
      @(posedge cpu_clk);
      #2;
      cpu_rst = 1'b1;
      set_idle();
      next_cycle();
   endtask

   task automatic test_fwd_priority();
      for (int i = 0; i < 4; i++) begin
         set_idle();
         id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_en = 1'b1; id_rs2_en = 1'b1;
         id_rf_rdata1 = 32'h99; id_rf_rdata2 = 32'h88;
         case (i)
            0: begin
               id_rs2 = 5'd9;
               set_stg(3'b101, 3'b101, 3'b000, 5'd5, 5'd0, 5'd5);
               push(C_NONE, 1'b1, 32'h11, 1'b1, 32'h88);
            end
            1: begin
               id_rs2 = 5'd9;
               set_stg(3'b100, 3'b100, 3'b000, 5'd0, 5'd0, 5'd5);
               push(C_NONE, 1'b1, 32'h22, 1'b1, 32'h88);
            end
            2: begin
               id_rs2 = 5'd5;
               set_stg(3'b111, 3'b101, 3'b000, 5'd5, 5'd5, 5'd5);
               push(C_NONE, 1'b1, 32'h11, 1'b1, 32'h11);
            end
            default: begin
               id_rs2 = 5'd5;
               set_stg(3'b110, 3'b111, 3'b000, 5'd5, 5'd5, 5'd5);
               push(C_NONE, 1'b1, 32'h33, 1'b1, 32'h33);
            end
         endcase
         @(negedge cpu_clk);
         e = sb.pop_front();
         n_vec++;
         if (ctl !== e.ctl) begin
            n_err++; $display("FAIL fwd_ctl[%0d]: got %b want %b", i, ctl, e.ctl);
         end
         n_vec++;
         if (e.chk1 && fwd_data1 !== e.d1) begin
            n_err++; $display("FAIL fwd_d1[%0d]: got %h want %h", i, fwd_data1, e.d1);
         end
         n_vec++;
         if (e.chk2 && fwd_data2 !== e.d2) begin
            n_err++; $display("FAIL fwd_d2[%0d]: got %h want %h", i, fwd_data2, e.d2);
         end
         next_cycle();
      end
   endtask

   task automatic test_x0_guard();
      set_idle();
      id_valid = 1'b1; id_rs2 = 5'd0; id_rs2_en = 1'b1; id_rf_rdata2 = 32'h1234;
      stg_valid = 3'b001; stg_wen = 3'b001; stg_rd = '0; stg_data = {64'h0, 32'hDEAD};
      push(C_NONE, 1'b0, 32'h0, 1'b1, 32'h0);
      @(negedge cpu_clk);
      e = sb.pop_front();
      n_vec++;
      if (fwd_data2 !== e.d2 || ctl !== e.ctl) begin
         n_err++; $display("FAIL x0_guard: got %h/%b want %h/%b", fwd_data2, ctl, e.d2, e.ctl);
      end
      next_cycle();
   endtask

   task automatic test_load_use();
      for (int i = 0; i < 5; i++) begin
         set_idle();
         id_valid = 1'b1; id_rs1 = 5'd7; id_rs1_en = 1'b1;
         case (i)
            0: begin
               set_stg(3'b001, 3'b001, 3'b001, 5'd7, 5'd0, 5'd0);
               push(C_STALL, 1'b0, 32'h0, 1'b0, 32'h0);
               m_stall++;
            end
            1: begin
               set_stg(3'b010, 3'b010, 3'b010, 5'd0, 5'd7, 5'd0);
               push(C_NONE, 1'b1, 32'h33, 1'b0, 32'h0);
            end
            2: begin
               id_valid = 1'b0;
               set_stg(3'b001, 3'b001, 3'b001, 5'd7, 5'd0, 5'd0);
               push(C_NONE, 1'b0, 32'h0, 1'b0, 32'h0);
            end
            3: begin
               id_rs1_en = 1'b0; id_rs2 = 5'd7; id_rs2_en = 1'b1;
               set_stg(3'b001, 3'b001, 3'b001, 5'd7, 5'd0, 5'd0);
               push(C_STALL, 1'b0, 32'h0, 1'b0, 32'h0);
               m_stall++;
            end
            default: begin
               id_rs1_en = 1'b0;
               set_stg(3'b001, 3'b001, 3'b001, 5'd7, 5'd0, 5'd0);
               push(C_NONE, 1'b0, 32'h0, 1'b0, 32'h0);
            end
         endcase
         @(negedge cpu_clk);
         e = sb.pop_front();
         n_vec++;
         if (ctl !== e.ctl) begin
            n_err++; $display("FAIL load_use_ctl[%0d]: got %b want %b", i, ctl, e.ctl);
         end
         if (e.chk1) begin
            n_vec++;
            if (fwd_data1 !== e.d1) begin
               n_err++; $display("FAIL load_use_d1[%0d]: got %h want %h", i, fwd_data1, e.d1);
            end
         end
         if (i == 1) begin
            n_vec++;
            if (stall_cnt !== CNT_W'(m_stall)) begin
               n_err++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, m_stall);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_redirect_vs_load();
      set_idle();
      id_valid = 1'b1; id_rs1 = 5'd7; id_rs1_en = 1'b1; ex_redirect = 1'b1;
      set_stg(3'b001, 3'b001, 3'b001, 5'd7, 5'd0, 5'd0);
      push(C_FLUSH, 1'b0, 32'h0, 1'b0, 32'h0);
      m_flush++;
      @(negedge cpu_clk);
      e = sb.pop_front();
      n_vec++;
      if (ctl !== e.ctl) begin
         n_err++; $display("FAIL redir_ctl: got %b want %b", ctl, e.ctl);
      end
      next_cycle();
      set_idle();
      @(negedge cpu_clk);
      n_vec++;
      if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
         n_err++; $display("FAIL redir_cnt: got %0d/%0d want %0d/%0d",
                           stall_cnt, flush_cnt, m_stall, m_flush);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back_deferred();
      for (int i = 0; i < 5; i++) begin
         set_idle();
         if (i < 3) begin
            mem_ready = 1'b0;
            ex_redirect = (i != 1);
            id_valid = 1'b1; id_rs1 = 5'd7; id_rs1_en = 1'b1;
            set_stg(3'b001, 3'b001, 3'b001, 5'd7, 5'd0, 5'd0);
            push(C_FREEZE, 1'b0, 32'h0, 1'b0, 32'h0);
            m_wait++;
         end else if (i == 3) begin
            push(C_FLUSH, 1'b0, 32'h0, 1'b0, 32'h0);
            m_flush++;
         end else begin
            push(C_NONE, 1'b0, 32'h0, 1'b0, 32'h0);
         end
         @(negedge cpu_clk);
         e = sb.pop_front();
         n_vec++;
         if (ctl !== e.ctl) begin
            n_err++; $display("FAIL deferred_ctl[%0d]: got %b want %b", i, ctl, e.ctl);
         end
         next_cycle();
      end
      n_vec++;
      if (wait_cnt !== CNT_W'(m_wait) || flush_cnt !== CNT_W'(m_flush) ||
          stall_cnt !== CNT_W'(m_stall)) begin
         n_err++; $display("FAIL deferred_cnt: got %0d/%0d/%0d want %0d/%0d/%0d",
                           wait_cnt, flush_cnt, stall_cnt, m_wait, m_flush, m_stall);
      end
   endtask

   task automatic test_saturation_reset();
      set_idle();
      mem_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         ex_redirect = (i == 19);
         m_wait++;
         next_cycle();
      end
      ex_redirect = 1'b0;
      @(negedge cpu_clk);
      n_vec++;
      if (wait_cnt !== CNT_W'(sat(m_wait))) begin
         n_err++; $display("FAIL sat_wait: got %0d want %0d", wait_cnt, sat(m_wait));
      end
      #1;
      cpu_rst = 1'b0;
      id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_en = 1'b1;
      set_stg(3'b001, 3'b001, 3'b000, 5'd5, 5'd0, 5'd0);
      #1;
      m_stall = 0; m_flush = 0; m_wait = 0;
      n_vec++;
      if ({stall_cnt, flush_cnt, wait_cnt} !== 12'h000 || ctl !== C_NONE) begin
         n_err++; $display("FAIL rst_mid_freeze: got cnt %h ctl %b want 000 00000",
                           {stall_cnt, flush_cnt, wait_cnt}, ctl);
      end
      n_vec++;
      if (fwd_data1 !== 32'hA1A1_0001) begin
         n_err++; $display("FAIL rst_fwd: got %h want %h", fwd_data1, 32'hA1A1_0001);
      end
      next_cycle();
      cpu_rst = 1'b1;
      set_idle();
      for (int i = 0; i < 2; i++) begin
         push(C_NONE, 1'b0, 32'h0, 1'b0, 32'h0);
         @(negedge cpu_clk);
         e = sb.pop_front();
         n_vec++;
         if (ctl !== e.ctl) begin
            n_err++; $display("FAIL post_rst_flush[%0d]: got %b want %b", i, ctl, e.ctl);
         end
         next_cycle();
      end
      n_vec++;
      if (flush_cnt !== CNT_W'(m_flush) || wait_cnt !== CNT_W'(m_wait)) begin
         n_err++; $display("FAIL post_rst_cnt: got %0d/%0d want %0d/%0d",
                           flush_cnt, wait_cnt, m_flush, m_wait);
      end
   endtask

   initial begin
      set_idle();
      cpu_rst = 1'b0;
      test_reset();
      test_fwd_priority();
      test_x0_guard();
      test_load_use();
      test_redirect_vs_load();
      test_back_to_back_deferred();
      test_saturation_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.
- Replaces the fixed 3-source forwarding and single-shot hazard logic with:
  - a configurable number of forwarding stages;
  - a configurable load-result availability stage;
  - bus wait-state freezing;
  - deferred redirect flushes;
  - saturating performance counters.
- Sits beside the ID stage. It drives the stall and flush controls of the PC and every pipeline register.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.
- NSTG, 3, number of forwarding stages behind ID. Index 0 is the youngest (EX), index NSTG-1 is the oldest (WB).
- LOAD_RDY_STG, 1, lowest stage index at which load data is valid on stg_data.
- CNT_W, 32, performance counter width.

Ports:
- cpu_clk  in  1  pipeline clock
- cpu_rst  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  RA_W each  ID source registers
- id_rs1_en, id_rs2_en  in  1 each  source actually read
- id_rf_rdata1, id_rf_rdata2  in  XLEN each  register-file read data
- stg_valid  in  NSTG  stage holds a real instruction
- stg_wen  in  NSTG  stage writes rd
- stg_is_load  in  NSTG  stage instruction is a load
- stg_rd  in  NSTG*RA_W  destination per stage, packed with index 0 in the LSBs
- stg_data  in  NSTG*XLEN  forwardable result per stage
- ex_redirect  in  1  single-cycle pulse: taken branch or jump resolved in EX
- mem_ready  in  1  bus access in MEM completes this cycle
- fwd_data1, fwd_data2  out  XLEN each  resolved operands to ID/EX
- stall_pc, stall_ifid  out  1 each  hold PC and IF/ID
- bubble_idex  out  1  load NOP into ID/EX
- flush_ifid  out  1  load NOP into IF/ID
- freeze  out  1  hold every pipeline register
- stall_cnt, flush_cnt, wait_cnt  out  CNT_W each  performance counters

Behaviour:
- Forwarding is combinational:
  - For each source, scan stages 0..NSTG-1 and take the first stage with stg_valid & stg_wen & stg_rd==rs & rs!=0.
  - The youngest stage wins. If no stage matches, pass the RF data.
  - rs==0 always yields 0.
- Load-use hazard:
  - The matching stage k has stg_is_load=1 and k<LOAD_RDY_STG, and that source's _en=1 and id_valid=1.
  - Response: stall_pc=stall_ifid=bubble_idex=1.
  - Forwarded data is don't-care. The stall repeats each cycle until the load reaches LOAD_RDY_STG.
- Freeze:
  - mem_ready=0 forces freeze=stall_pc=stall_ifid=1, bubble_idex=0 and flush_ifid=0.
  - Freeze has the highest priority.
- Redirect:
  - With ex_redirect=1 and mem_ready=1: flush_ifid=bubble_idex=1 and stall_pc=0, so the PC takes the target.
  - Redirect overrides a simultaneous load-use stall, because the ID instruction is squashed.
- Deferred redirect:
  - ex_redirect=1 while mem_ready=0 sets the pend_redir register.
  - On the first cycle with mem_ready=1, pend_redir causes the same flush as a redirect, then clears.
  - A second redirect while pending is absorbed, leaving one flush.
- Priority: freeze > redirect (live or pending) > load-use > forward.
- Counters, all saturating at 2^CNT_W-1 with no wrap:
  - stall_cnt increments on each load-use stall cycle.
  - flush_cnt increments on each applied flush.
  - wait_cnt increments on each mem_ready=0 cycle.
- Reset (cpu_rst=0, async):
  - pend_redir and all counters clear to 0.
  - All control outputs are 0.
  - fwd_data outputs equal RF data.
  - A reset asserted mid-freeze discards the pending redirect.
- Latency: controls and forwarding are 0-cycle combinational from the inputs; pend_redir and the counters update on the cpu_clk rising edge.

Test Plan:
- Forward priority:
  - Setup: stg0 and stg2 both write x5, stg_data0=0x11, stg_data2=0x22; id_rs1=5.
  - Required: fwd_data1=0x11, no stalls.
- x0 guard:
  - Setup: stg0 writes x0 with data 0xDEAD; id_rs2=0, rs2_en=1.
  - Required: fwd_data2=0, no forward.
- Load-use:
  - Setup: stg0 is a load to x7; ID reads x7.
  - Required: one cycle of stall_pc=stall_ifid=bubble_idex=1.
  - Next cycle, with the load in stg1: fwd_data1=stg_data1 and no stall.
  - stall_cnt=1.
- Redirect vs load-use:
  - Setup: ex_redirect=1 together with a load-use condition.
  - Required: flush_ifid=bubble_idex=1, stall_pc=0, stall_cnt unchanged, flush_cnt=1.
- Deferred redirect:
  - Setup: mem_ready=0 for 3 cycles, with an ex_redirect pulse in cycle 1.
  - Required during the wait: freeze=1 and no flush, wait_cnt=3.
  - On release: exactly one flush cycle, pend_redir=0.
- Saturation and reset:
  - Setup: CNT_W=4 with 20 wait cycles.
  - Required: wait_cnt=15.
  - Then assert cpu_rst=0 mid-freeze with a redirect pending: all counters are 0 and no flush occurs after release.
